// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bus bundle between the fetch unit, its instruction memory
//                and the decode stage.
//                  rom_pc    - read address to instruction memory
//                  rom_instr - instruction memory data (combinational)
//                  out_valid / out_ready - decode handshake
//                  out_instr / out_pc    - registered instruction and address
//                master modport: fetch side; slave modport: memory/decode side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int PcWidth    = 10,
   parameter int InstrWidth = 128
);
   logic [PcWidth-1:0]    rom_pc;
   logic [InstrWidth-1:0] rom_instr;
   logic                  out_valid;
   logic                  out_ready;
   logic [InstrWidth-1:0] out_instr;
   logic [PcWidth-1:0]    out_pc;

   modport master (
      output rom_pc,
      input  rom_instr,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  rom_pc,
      output rom_instr,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Reads the instruction memory at the
//                current PC, registers the word and its address towards
//                decode with a valid/ready handshake, follows branch
//                redirects and stops on the halt opcode (top byte 8'hFF).
//  Ports       : clk           - rising-edge clock
//                rstn          - asynchronous active-low reset
//                start         - pulse: begin fetching at StartPc
//                branch_taken  - redirect request from execute
//                branch_target - redirect PC
//                bus           - fetch_unit_if.master (memory + decode)
//                halted        - high while in HALT
//                instr_count   - saturating count of accepted handshakes
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int          PcWidth    = 10,
   parameter int          InstrWidth = 128,
   parameter int unsigned StartPc    = 0
) (
   input  wire logic               clk,
   input  wire logic               rstn,
   input  wire logic               start,
   input  wire logic               branch_taken,
   input  wire logic [PcWidth-1:0] branch_target,
   fetch_unit_if.master            bus,
   output      logic               halted,
   output      logic [15:0]        instr_count
);

   localparam logic [PcWidth-1:0] c_START_PC = PcWidth'(StartPc);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FETCH = 2'd1;
   localparam logic [1:0] c_HALT  = 2'd2;

   logic [1:0]            r_state;
   logic [PcWidth-1:0]    r_pc;
   logic [PcWidth-1:0]    r_out_pc;
   logic [InstrWidth-1:0] r_out_instr;
   logic                  r_out_valid;
   logic [15:0]           r_count;

   logic w_accept;
   logic w_slot_free;
   logic w_is_halt;
   logic w_restart;

   assign w_accept    = r_out_valid & bus.out_ready;
   // The output register can take a new word when empty or draining this cycle.
   assign w_slot_free = ~r_out_valid | bus.out_ready;
   assign w_is_halt   = (bus.rom_instr[InstrWidth-1 -: 8] == 8'hFF);
   // start only acts outside FETCH; inside FETCH it is ignored.
   assign w_restart   = start & (r_state != c_FETCH);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= c_IDLE;
         r_pc        <= c_START_PC;
         r_out_pc    <= '0;
         r_out_instr <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_pc        <= c_START_PC;
               r_out_valid <= 1'b0;
               if (start) begin
                  r_state <= c_FETCH;
               end
            end
            c_FETCH: begin
               // A redirect beats a load and discards any pending word.
               if (branch_taken) begin
                  r_out_valid <= 1'b0;
                  r_pc        <= branch_target;
               end else if (w_slot_free) begin
                  r_out_instr <= bus.rom_instr;
                  r_out_pc    <= r_pc;
                  r_out_valid <= 1'b1;
                  r_pc        <= r_pc + PcWidth'(1);
                  if (w_is_halt) begin
                     r_state <= c_HALT;
                  end
               end
            end
            c_HALT: begin
               if (start) begin
                  r_pc        <= c_START_PC;
                  r_out_valid <= 1'b0;
                  r_state     <= c_FETCH;
               end else if (w_accept) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= c_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_count <= '0;
      end else if (w_restart) begin
         r_count <= '0;
      end else if (w_accept && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign bus.rom_pc    = r_pc;
   assign bus.out_valid = r_out_valid;
   assign bus.out_instr = r_out_instr;
   assign bus.out_pc    = r_out_pc;
   assign halted        = (r_state == c_HALT);
   assign instr_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A reference model
//                predicts the stream of accepted instructions into a
//                scoreboard queue; a negedge monitor pops and compares on
//                each handshake and checks stall stability and instr_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;
   localparam int PW = 10;
   localparam int IW = 128;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          branch_taken;
   logic [PW-1:0] branch_target;
   logic          halted;
   logic [15:0]   instr_count;

   fetch_unit_if #(.PcWidth(PW), .InstrWidth(IW)) bus ();

   logic [IW-1:0] rom [0:1023];
   assign bus.rom_instr = rom[bus.rom_pc];

   fetch_unit #(.PcWidth(PW), .InstrWidth(IW), .StartPc(0)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .bus           (bus.master),
      .halted        (halted),
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   // Reference model: expected accepted instructions, in order.
   logic [PW-1:0] q_pc[$];
   logic [IW-1:0] q_instr[$];
   logic [PW-1:0] mdl_next;
   bit            mdl_active;
   bit            mdl_stop;
   int            mon_total;
   int            cnt_base;
   int            checks;
   int            failures;

   bit            hold_flag;
   logic [PW-1:0] hold_pc;
   logic [IW-1:0] hold_instr;

   task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sequential fetch from mdl_next, stopping after a halt opcode.
   task automatic refill();
      while (mdl_active && !mdl_stop && q_pc.size() < 8) begin
         q_pc.push_back(mdl_next);
         q_instr.push_back(rom[mdl_next]);
         if (rom[mdl_next][IW-1 -: 8] == 8'hFF) mdl_stop = 1'b1;
         mdl_next = mdl_next + 1'b1;
      end
   endtask

   task automatic model_restart(input logic [PW-1:0] pc);
      q_pc.delete();
      q_instr.delete();
      mdl_next   = pc;
      mdl_stop   = 1'b0;
      mdl_active = 1'b1;
      refill();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      refill();
   endtask

   // Monitor: checks the values the DUT presents during each cycle.
   initial begin
      hold_flag = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn !== 1'b1) begin
            hold_flag = 1'b0;
         end else begin
            chk("instr_count", IW'(instr_count), IW'(16'(mon_total - cnt_base)));
            if (hold_flag) begin
               chk("stall_valid", IW'(bus.out_valid), IW'(1'b1));
               chk("stall_pc", IW'(bus.out_pc), IW'(hold_pc));
               chk("stall_instr", bus.out_instr, hold_instr);
            end
            hold_flag = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
               if (q_pc.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_unexpected actual pc=%0h required=no_handshake at %0t", bus.out_pc, $time);
               end else begin
                  chk("sb_pc", IW'(bus.out_pc), IW'(q_pc.pop_front()));
                  chk("sb_instr", bus.out_instr, q_instr.pop_front());
               end
               mon_total++;
            end else if (bus.out_valid && !branch_taken && !start) begin
               hold_flag  = 1'b1;
               hold_pc    = bus.out_pc;
               hold_instr = bus.out_instr;
            end
         end
      end
   end

   initial begin
      checks = 0; failures = 0; mon_total = 0; cnt_base = 0;
      mdl_active = 1'b0; mdl_stop = 1'b0; mdl_next = '0;
      rstn = 1'b0; start = 1'b0; branch_taken = 1'b0; branch_target = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 1024; i++) rom[i] = {8'h00, 56'h0, 32'(i), 32'($urandom)};
      rom[5][IW-1 -: 8] = 8'hFF;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", IW'(bus.out_valid), '0);
      chk("rst_pc", IW'(bus.out_pc), '0);
      chk("rst_instr", bus.out_instr, '0);
      chk("rst_halted", IW'(halted), '0);
      chk("rst_count", IW'(instr_count), '0);
      chk("rst_rom_pc", IW'(bus.rom_pc), '0);
      rstn = 1'b1;
      tick(); tick();
      chk("idle_valid", IW'(bus.out_valid), '0);

      // Straight run into the halt word at address 5
      bus.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      model_restart('0);
      cnt_base = mon_total;
      tick();
      chk("first_valid", IW'(bus.out_valid), IW'(1'b1));
      chk("first_pc", IW'(bus.out_pc), '0);
      repeat (6) tick();
      chk("halt_halted", IW'(halted), IW'(1'b1));
      chk("halt_count", IW'(instr_count), IW'(16'd6));
      chk("halt_valid", IW'(bus.out_valid), '0);

      // start together with branch in HALT: start wins
      start = 1'b1; branch_taken = 1'b1; branch_target = 10'h200;
      tick();
      start = 1'b0; branch_taken = 1'b0;
      model_restart('0);
      cnt_base = mon_total;
      chk("restart_halted", IW'(halted), '0);
      chk("restart_count", IW'(instr_count), '0);
      chk("restart_rom_pc", IW'(bus.rom_pc), '0);
      chk("restart_valid", IW'(bus.out_valid), '0);

      // Stall three cycles at out_pc=2
      repeat (3) tick();
      chk("pre_stall_pc", IW'(bus.out_pc), IW'(10'd2));
      bus.out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("stall_hold_pc", IW'(bus.out_pc), IW'(10'd2));
         chk("stall_rom_pc", IW'(bus.rom_pc), IW'(10'd3));
         chk("stall_hold_instr", bus.out_instr, rom[2]);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("resume_pc", IW'(bus.out_pc), IW'(10'd3));

      // Branch while out_pc=3 is pending and not accepted
      bus.out_ready = 1'b0; branch_taken = 1'b1; branch_target = 10'h200;
      tick();
      branch_taken = 1'b0;
      model_restart(10'h200);
      chk("br_valid", IW'(bus.out_valid), '0);
      chk("br_rom_pc", IW'(bus.rom_pc), IW'(10'h200));
      chk("br_count", IW'(instr_count), IW'(16'd3));
      bus.out_ready = 1'b1;
      tick();
      chk("br_target_pc", IW'(bus.out_pc), IW'(10'h200));

      // Wrap at the top of the address space
      branch_taken = 1'b1; branch_target = 10'h3FF;
      tick();
      branch_taken = 1'b0;
      model_restart(10'h3FF);
      tick();
      chk("wrap_pc_top", IW'(bus.out_pc), IW'(10'h3FF));
      tick();
      chk("wrap_pc_zero", IW'(bus.out_pc), '0);

      // Asynchronous reset mid-fetch
      rstn = 1'b0;
      #1;
      q_pc.delete(); q_instr.delete(); mdl_active = 1'b0;
      cnt_base = mon_total;
      chk("arst_valid", IW'(bus.out_valid), '0);
      chk("arst_pc", IW'(bus.out_pc), '0);
      chk("arst_instr", bus.out_instr, '0);
      chk("arst_halted", IW'(halted), '0);
      chk("arst_count", IW'(instr_count), '0);
      chk("arst_rom_pc", IW'(bus.rom_pc), '0);
      tick();
      rstn = 1'b1;
      repeat (4) tick();
      chk("arst_no_fetch", IW'(bus.out_valid), '0);

      // Randomised run without halt words
      rom[5][IW-1 -: 8] = 8'h00;
      bus.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      model_restart('0);
      cnt_base = mon_total;
      for (int n = 0; n < 3000; n++) begin
         bus.out_ready = ($urandom_range(3) != 0);
         if ($urandom_range(19) == 0) begin
            branch_taken  = 1'b1;
            branch_target = ($urandom_range(3) == 0) ? PW'(10'h3FC + $urandom_range(3))
                                                     : PW'($urandom);
         end
         if ($urandom_range(49) == 0) start = 1'b1;
         tick();
         if (branch_taken) model_restart(branch_target);
         branch_taken = 1'b0;
         start        = 1'b0;
      end
      chk("rand_not_halted", IW'(halted), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PcWidth, default 10, meaning program counter and instruction-memory address width.
REQ-002 The block SHALL have parameter InstrWidth, default 128, meaning instruction word width.
REQ-003 The block SHALL have parameter StartPc, default 0, meaning PC loaded on reset and on start.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins fetching at StartPc.
REQ-007 The block SHALL have port branch_taken, input, 1 bit: redirect request from execute.
REQ-008 The block SHALL have port branch_target, input, PcWidth bits: redirect PC.
REQ-009 The block SHALL have port rom_pc, output, PcWidth bits: read address to the instruction memory, equal to the current PC register.
REQ-010 The block SHALL have port rom_instr, input, InstrWidth bits: instruction memory data, combinational from rom_pc.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a valid instruction for decode.
REQ-012 The block SHALL have port out_ready, input, 1 bit: decode accepts when out_valid and out_ready are both 1.
REQ-013 The block SHALL have port out_instr, output, InstrWidth bits, and port out_pc, output, PcWidth bits: registered instruction and its address.
REQ-014 The block SHALL have port halted, output, 1 bit, high in state HALT.
REQ-015 The block SHALL have port instr_count, output, 16 bits: count of accepted handshakes.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, HALT.
REQ-017 In IDLE, the block SHALL hold PC at StartPc and out_valid at 0, and on start SHALL enter FETCH.
REQ-018 In FETCH, a "load" SHALL occur in any cycle with out_valid=0 or (out_valid=1 and out_ready=1).
- Effect: out_instr<=rom_instr, out_pc<=PC, out_valid<=1, PC<=PC+1.
REQ-019 PC increment SHALL wrap modulo 2^PcWidth (1023 -> 0 at default width).
REQ-020 With out_valid=1 and out_ready=0, out_instr, out_pc, out_valid and PC SHALL hold unchanged.
REQ-021 A loaded instruction whose bits [InstrWidth-1:InstrWidth-8] equal 8'hFF is the halt instruction.
- On that load, the block SHALL still present the instruction and SHALL enter HALT; PC still increments.
REQ-022 In HALT, no load SHALL occur; out_valid SHALL clear once the pending instruction is accepted.
REQ-023 branch_taken in FETCH SHALL have priority over a load in the same cycle.
- Effect: out_valid<=0 (any pending instruction is discarded), PC<=branch_target, state stays FETCH.
- First instruction from the target is presented the following cycle.
REQ-024 branch_taken SHALL be ignored in IDLE and HALT.
REQ-025 start in FETCH SHALL be ignored.
REQ-026 start in HALT SHALL set PC<=StartPc, out_valid<=0 and enter FETCH.
- start and branch_taken together in HALT: start wins.
REQ-027 instr_count SHALL increment by 1 on each out_valid and out_ready handshake.
- It SHALL saturate at 16'hFFFF and SHALL clear on start.
REQ-028 Throughput SHALL be one instruction per cycle with out_ready held at 1; latency from start to first out_valid SHALL be one cycle after FETCH entry.

Reset
REQ-029 While rstn=0, the block SHALL asynchronously force the following values, and SHALL release on the first clk edge after rstn rises:
- state=IDLE, PC=StartPc, out_valid=0, out_instr=0, out_pc=0, halted=0, instr_count=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending instruction with no handshake counted.

Verification
REQ-031 Memory preloaded with words 0..4, word 5 opcode 8'hFF; start with out_ready=1 -> out_pc 0..5 on consecutive cycles, halted=1, instr_count=6, out_valid=0 afterwards.
REQ-032 out_ready=0 for 3 cycles at out_pc=2 -> out_instr/out_pc/rom_pc stable; resume -> out_pc 3 next, no instruction skipped or duplicated.
REQ-033 branch_taken=1, branch_target=10'h200 while out_pc=3 valid and out_ready=0 -> instruction 3 dropped, next out_pc=10'h200, instr_count unchanged by the drop.
REQ-034 branch_target=10'h3FF, no halt -> out_pc 10'h3FF followed by 10'h000.
REQ-035 rstn pulsed low mid-FETCH -> all outputs at reset values immediately; fetch restarts only after a new start.
REQ-036 HALT reached, then start and branch_taken in the same cycle -> fetch restarts at StartPc, instr_count=0.
